// File: rtl/laser500_kbd_pkg.sv
// Shared constants, types and keymap helpers for the Laser 350/500/700 PS/2 keyboard front end.
// Keymap ({ext, code} -> row/col), every other code is unmapped:
//   row 0: 16 '1' c0, 1E '2' c1, 26 '3' c2, 25 '4' c3, 2E '5' c4
//   row 1: 15 Q c0, 1D W c1, 24 E c2, 2D R c3, 1C A c4, 1B S c5
//   row 2: 23 D c0, 2B F c1, 34 G c2, 33 H c3
//   row 3: 1A Z c0, 22 X c1, 21 C c2, 2A V c3
//   row 4: 32 B c0, 31 N c1, 3A M c2, 29 Space c4
//   row 5: 36 '6' c0, 3D '7' c1, 3E '8' c2, 46 '9' c3, 45 '0' c4
//   row 6: 2C T c0, 35 Y c1, 5A Enter c2, 3C U c3
//   row 7: 43 I c0, 44 O c1, 4D P c2
//   row 8: 3B J c0, 42 K c1, 4B L c2
//   row 9: 12 Shift c0, 14 Ctrl c1, 66 Backspace c2
//   row 10: E0 75 Up c0, E0 72 Down c1, E0 6B Left c2, E0 74 Right c3
package laser500_kbd_pkg;

    localparam int ROWS = 11;
    localparam int COLS = 7;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic [2:0] col;
    } key_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } rx_state_e;

    function automatic key_entry_t key_at(input logic [3:0] r, input logic [2:0] c);
        key_entry_t e;
        e.valid = 1'b1;
        e.row   = r;
        e.col   = c;
        return e;
    endfunction

endpackage

// File: rtl/laser500_keymap.sv
// Combinational lookup from {ext, scancode} to a matrix position; misses return valid = 0.
module laser500_keymap
    import laser500_kbd_pkg::*;
(
    input  logic [8:0] key_i,
    output key_entry_t entry_o
);

    always_comb begin
        entry_o = '0;
        case (key_i)
            9'h016: entry_o = key_at(4'd0, 3'd0);
            9'h01E: entry_o = key_at(4'd0, 3'd1);
            9'h026: entry_o = key_at(4'd0, 3'd2);
            9'h025: entry_o = key_at(4'd0, 3'd3);
            9'h02E: entry_o = key_at(4'd0, 3'd4);
            9'h015: entry_o = key_at(4'd1, 3'd0);
            9'h01D: entry_o = key_at(4'd1, 3'd1);
            9'h024: entry_o = key_at(4'd1, 3'd2);
            9'h02D: entry_o = key_at(4'd1, 3'd3);
            9'h01C: entry_o = key_at(4'd1, 3'd4);
            9'h01B: entry_o = key_at(4'd1, 3'd5);
            9'h023: entry_o = key_at(4'd2, 3'd0);
            9'h02B: entry_o = key_at(4'd2, 3'd1);
            9'h034: entry_o = key_at(4'd2, 3'd2);
            9'h033: entry_o = key_at(4'd2, 3'd3);
            9'h01A: entry_o = key_at(4'd3, 3'd0);
            9'h022: entry_o = key_at(4'd3, 3'd1);
            9'h021: entry_o = key_at(4'd3, 3'd2);
            9'h02A: entry_o = key_at(4'd3, 3'd3);
            9'h032: entry_o = key_at(4'd4, 3'd0);
            9'h031: entry_o = key_at(4'd4, 3'd1);
            9'h03A: entry_o = key_at(4'd4, 3'd2);
            9'h029: entry_o = key_at(4'd4, 3'd4);
            9'h036: entry_o = key_at(4'd5, 3'd0);
            9'h03D: entry_o = key_at(4'd5, 3'd1);
            9'h03E: entry_o = key_at(4'd5, 3'd2);
            9'h046: entry_o = key_at(4'd5, 3'd3);
            9'h045: entry_o = key_at(4'd5, 3'd4);
            9'h02C: entry_o = key_at(4'd6, 3'd0);
            9'h035: entry_o = key_at(4'd6, 3'd1);
            9'h05A: entry_o = key_at(4'd6, 3'd2);
            9'h03C: entry_o = key_at(4'd6, 3'd3);
            9'h043: entry_o = key_at(4'd7, 3'd0);
            9'h044: entry_o = key_at(4'd7, 3'd1);
            9'h04D: entry_o = key_at(4'd7, 3'd2);
            9'h03B: entry_o = key_at(4'd8, 3'd0);
            9'h042: entry_o = key_at(4'd8, 3'd1);
            9'h04B: entry_o = key_at(4'd8, 3'd2);
            9'h012: entry_o = key_at(4'd9, 3'd0);
            9'h014: entry_o = key_at(4'd9, 3'd1);
            9'h066: entry_o = key_at(4'd9, 3'd2);
            9'h175: entry_o = key_at(4'd10, 3'd0);
            9'h172: entry_o = key_at(4'd10, 3'd1);
            9'h16B: entry_o = key_at(4'd10, 3'd2);
            9'h174: entry_o = key_at(4'd10, 3'd3);
            default: entry_o = '0;
        endcase
    end

endmodule

// File: rtl/laser500_keyboard.sv
// PS/2 receiver, make/break decoder and key matrix with the active-low row/column read path
// used by the Z80 keyboard port.
module laser500_keyboard
    import laser500_kbd_pkg::*;
#(
    parameter int CLK_HZ     = 4000000,
    parameter int TIMEOUT_US = 2000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    input  logic [ROWS-1:0] row_sel_n,
    input  logic            clear,
    output logic [COLS-1:0] col_n,
    output logic            scan_valid,
    output logic [7:0]      scan_code,
    output logic            frame_err
);

    localparam int          TO_LIMIT_INT = (CLK_HZ / 1000000) * TIMEOUT_US - 1;
    localparam logic [15:0] TO_LIMIT     = TO_LIMIT_INT[15:0];

    if (TO_LIMIT_INT < 1 || TO_LIMIT_INT > 65535) begin : g_limit_check
        $error("laser500_keyboard: timeout limit does not fit the 16-bit timer");
    end

    logic [2:0]            ps2c_q;
    logic [1:0]            ps2d_q;
    rx_state_e             state_q, state_d;
    logic [3:0]            bitcnt_q, bitcnt_d;
    logic [8:0]            shreg_q, shreg_d;
    logic [15:0]           timer_q, timer_d;
    logic                  scan_valid_q, frame_err_q;
    logic [7:0]            scan_code_q;
    logic                  ext_q, ext_d, brk_q, brk_d;
    logic [ROWS-1:0][COLS-1:0] matrix_q, matrix_d;

    logic       fall, rx_bit;
    logic       start_rx, shift_en, stop_edge, timeout;
    logic       frame_ok, accept, err;
    logic [7:0] rx_byte;
    key_entry_t entry;

    // Synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2c_q <= '1;
            ps2d_q <= '1;
        end else begin
            ps2c_q <= {ps2c_q[1:0], ps2_clk};
            ps2d_q <= {ps2d_q[0], ps2_data};
        end
    end

    assign fall   = ~ps2c_q[1] & ps2c_q[2];
    assign rx_bit = ps2d_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fall && !rx_bit) state_d = ST_RX;
            ST_RX: begin
                if (fall && bitcnt_q == 4'd10)          state_d = ST_IDLE;
                else if (!fall && timer_q == TO_LIMIT)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_rx  = (state_q == ST_IDLE) && fall && !rx_bit;
        shift_en  = (state_q == ST_RX) && fall && (bitcnt_q != 4'd10);
        stop_edge = (state_q == ST_RX) && fall && (bitcnt_q == 4'd10);
        timeout   = (state_q == ST_RX) && !fall && (timer_q == TO_LIMIT);
    end

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    assign frame_ok = rx_bit & (^shreg_q);
    assign accept   = stop_edge & frame_ok;
    assign err      = (stop_edge & ~frame_ok) | timeout;
    assign rx_byte  = shreg_q[7:0];

    always_comb begin
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        timer_d  = timer_q;
        if (start_rx)      bitcnt_d = 4'd1;
        else if (shift_en) bitcnt_d = bitcnt_q + 4'd1;
        if (shift_en)      shreg_d = {rx_bit, shreg_q[8:1]};
        if (fall || timeout)          timer_d = '0;
        else if (state_q == ST_RX)    timer_d = timer_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            timer_q      <= '0;
            scan_valid_q <= 1'b0;
            scan_code_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            timer_q      <= timer_d;
            scan_valid_q <= accept;
            frame_err_q  <= err;
            if (accept) scan_code_q <= rx_byte;
        end
    end

    laser500_keymap u_keymap (
        .key_i   ({ext_q, rx_byte}),
        .entry_o (entry)
    );

    // Decoder acts on the byte as it is accepted so the matrix lands with scan_valid.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        matrix_d = matrix_q;
        if (accept) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (entry.valid) matrix_d[entry.row][entry.col] = brk_q;
            end
        end
        if (clear) begin
            matrix_d = '1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            matrix_q <= '1;
        end else begin
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            matrix_q <= matrix_d;
        end
    end

    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++) begin
            col_n = col_n & (matrix_q[r] | {COLS{row_sel_n[r]}});
        end
    end

    assign scan_valid = scan_valid_q;
    assign scan_code  = scan_code_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_laser500_keyboard.sv
// Bench for laser500_keyboard: PS/2 frames at 12.5 kHz, scancodes checked through an expected queue.
`timescale 1ns/1ps
module tb_laser500_keyboard;

  localparam int HALF   = 160;   // half PS/2 period in 4 MHz clk cycles
  localparam int GAP    = 40;
  // 2 synchroniser cycles + 1 cycle to restart the timer + 8000 counted cycles
  localparam int TO_RAW = 8003;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] row_sel_n = '1;
  logic        clear = 1'b0;
  logic [6:0]  col_n;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic        frame_err;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int exp_err = 0;
  int got_err = 0;

  always #125 clk = ~clk;

  laser500_keyboard dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .row_sel_n (row_sel_n),
    .clear     (clear),
    .col_n     (col_n),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every scan_valid cycle must match the oldest expected code
  always @(negedge clk) begin
    if (reset_n) begin
      if (scan_valid) begin
        check("scan_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("scan_code", 32'(scan_code), 32'(exp_q.pop_front()));
      end
      if (frame_err) got_err++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_flip,
                            input logic stop_bit, input logic clr_stop);
    logic [10:0] f;
    f = {stop_bit, ~(^code) ^ par_flip, code, 1'b0};
    if (!par_flip && stop_bit) exp_q.push_back(code);
    else exp_err++;
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && clr_stop) begin
        wait_cyc(2);
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        wait_cyc(HALF - 3);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic check_cols(input string tag, input logic [10:0] sel, input logic [6:0] exp);
    row_sel_n = sel;
    #10;
    check(tag, 32'(col_n), 32'(exp));
  endtask

  task automatic timeout_test();
    int  cnt;
    bit  seen;
    send_bits(4);
    ps2_data = 1'($urandom_range(0, 1));
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    exp_err++;
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 10000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == HALF) ps2_clk = 1'b1;
      if (frame_err) seen = 1;
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    check("timeout_cycles", 32'(cnt), 32'(TO_RAW));
    wait_cyc(5);
    check("err_timeout", 32'(got_err), 32'(exp_err));
  endtask

  initial begin
    wait_cyc(5);
    row_sel_n = '0;
    #10;
    check("rst_col_n", 32'(col_n), 32'h7F);
    check("rst_scan_valid", 32'(scan_valid), 32'd0);
    check("rst_scan_code", 32'(scan_code), 32'h00);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    wait_cyc(5);

    row_sel_n = 11'h7FD;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("a_scan_code", 32'(scan_code), 32'h1C);
    check_cols("a_press", 11'h7FD, 7'b1101111);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_cols("a_release", 11'h7FD, 7'h7F);

    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check_cols("up_press", 11'h3FF, 7'h7E);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check_cols("kp8_unmapped", 11'h3FF, 7'h7E);
    check_cols("kp8_all_rows", 11'h000, 7'h7E);

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("err_parity", 32'(got_err), 32'(exp_err));
    check_cols("parity_nochange", 11'h7FD, 7'h7F);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("err_stop", 32'(got_err), 32'(exp_err));
    check_cols("stop_nochange", 11'h7FD, 7'h7F);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_cols("a_enter", 11'h7BD, 7'b1101011);
    check_cols("enter_row", 11'h7BF, 7'b1111011);

    timeout_test();
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check_cols("space_press", 11'h7EF, 7'b1101111);

    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check_cols("space_release", 11'h7EF, 7'h7F);
    send_frame(8'h29, 1'b0, 1'b1, 1'b1);
    check_cols("clear_wins", 11'h000, 7'h7F);

    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_cols("clear_drops_brk", 11'h7FD, 7'b1101111);

    send_bits(4);
    reset_n = 1'b0;
    wait_cyc(4);
    check_cols("midrst_col_n", 11'h000, 7'h7F);
    check("midrst_scan_code", 32'(scan_code), 32'h00);
    reset_n = 1'b1;
    wait_cyc(20);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_cols("enter_after_rst", 11'h000, 7'b1111011);
    check_cols("a_after_rst", 11'h7FD, 7'h7F);

    wait_cyc(10);
    check("err_total", 32'(got_err), 32'(exp_err));
    check("scan_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #40ms;
    $display("FAIL watchdog: simulation exceeded 40 ms, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
